// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-stage decode inputs, live EX ALU flags, and per-stage control outputs.
// Master drives the instruction side; slave is the control unit.
interface pipe_ctrl_unit_if #(
   parameter int unsigned ALUOP_W = 3
);
   logic               instr_valid;
   logic [31:0]        instruction;
   logic               stall;
   logic               cbz_zero;
   logic               alu_negative;
   logic               alu_zero;
   logic               alu_carry;
   logic               alu_overflow;

   logic               reg2loc;
   logic               uncond_br;
   logic               br_taken;
   logic               flush;
   logic               stall_req;
   logic               illegal;
   logic               ex_alu_src;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic               mem_write;
   logic               wb_reg_write;
   logic               wb_mem_to_reg;
   logic [3:0]         flags;

   modport master (
      output instr_valid, instruction, stall, cbz_zero,
             alu_negative, alu_zero, alu_carry, alu_overflow,
      input  reg2loc, uncond_br, br_taken, flush, stall_req, illegal,
             ex_alu_src, ex_alu_op, mem_write, wb_reg_write, wb_mem_to_reg, flags
   );

   modport slave (
      input  instr_valid, instruction, stall, cbz_zero,
             alu_negative, alu_zero, alu_carry, alu_overflow,
      output reg2loc, uncond_br, br_taken, flush, stall_req, illegal,
             ex_alu_src, ex_alu_op, mem_write, wb_reg_write, wb_mem_to_reg, flags
   );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined LEGv8 control: ID decode/branch resolve, valid-tagged EX/MEM/WB control, NZCV register.
// CTRL_FLAG_FWD_EN: forward live EX flags to B.LT instead of stalling one cycle on a flag hazard.
module pipe_ctrl_unit #(
   parameter int unsigned ALUOP_W    = 3,
   parameter int unsigned MEM_STAGES = 1
) (
   input logic             clk,
   input logic             reset,
   pipe_ctrl_unit_if.slave bus
);
   localparam int unsigned NSTG  = MEM_STAGES + 1;
   localparam int unsigned OPC_W = 11;

   typedef struct packed {
      logic       valid;
      logic       alu_src;
      logic [2:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       set_flags;
   } ex_ctrl_t;

   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
   } mem_ctrl_t;

   logic [OPC_W-1:0] op;
   ex_ctrl_t         dec;
   logic             legal, rtype, is_b, is_cbz, is_blt;
   logic             hazard, lt_c, hold, stall_req_c, br_c, uncond_c;

   ex_ctrl_t  ex_q, ex_d;
   mem_ctrl_t mem_q [NSTG];
   mem_ctrl_t mem_d [NSTG];
   logic [3:0] flags_q, flags_d;

   logic unused_instr_bits;
   assign unused_instr_bits = ^bus.instruction[20:0];

   assign op = bus.instruction[31:21];

   // Opcode decode into EX-stage control bits
   always_comb begin
      dec    = '0;
      legal  = 1'b1;
      rtype  = 1'b0;
      is_b   = 1'b0;
      is_cbz = 1'b0;
      is_blt = 1'b0;
      casez (op)
         11'b11111000010: begin dec.alu_src = 1'b1; dec.alu_op = 3'b010;
                                dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; end
         11'b11111000000: begin dec.alu_src = 1'b1; dec.alu_op = 3'b010;
                                dec.mem_write = 1'b1; end
         11'b1001000100?: begin dec.alu_src = 1'b1; dec.alu_op = 3'b010;
                                dec.reg_write = 1'b1; end
         11'b10101011000: begin dec.alu_op = 3'b010; dec.reg_write = 1'b1;
                                dec.set_flags = 1'b1; rtype = 1'b1; end
         11'b11101011000: begin dec.alu_op = 3'b011; dec.reg_write = 1'b1;
                                dec.set_flags = 1'b1; rtype = 1'b1; end
         11'b10001010000: begin dec.alu_op = 3'b100; dec.reg_write = 1'b1; rtype = 1'b1; end
         11'b11001010000: begin dec.alu_op = 3'b110; dec.reg_write = 1'b1; rtype = 1'b1; end
         11'b11010011010: begin dec.alu_op = 3'b111; dec.reg_write = 1'b1; rtype = 1'b1; end
         11'b000101?????: is_b   = 1'b1;
         11'b10110100???: is_cbz = 1'b1;
         11'b01010100???: is_blt = 1'b1;
         default:         legal  = 1'b0;
      endcase
   end

   // Flag hazard, branch resolution and bubble insertion
   always_comb begin
      hazard = bus.instr_valid & is_blt & ex_q.valid & ex_q.set_flags;
`ifdef CTRL_FLAG_FWD_EN
      stall_req_c = 1'b0;
      lt_c        = hazard ? (bus.alu_negative ^ bus.alu_overflow) : (flags_q[3] ^ flags_q[0]);
`else
      stall_req_c = hazard;
      lt_c        = flags_q[3] ^ flags_q[0];
`endif
      hold     = bus.stall | stall_req_c;
      br_c     = bus.instr_valid & ~hold & (is_b | (is_cbz & bus.cbz_zero) | (is_blt & lt_c));
      uncond_c = bus.instr_valid & ~hold & is_b;
      ex_d     = '0;
      if (bus.instr_valid && legal && !hold) begin
         ex_d       = dec;
         ex_d.valid = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NSTG); i++) mem_d[i] = '0;
      mem_d[0] = '{valid: ex_q.valid, reg_write: ex_q.reg_write,
                   mem_to_reg: ex_q.mem_to_reg, mem_write: ex_q.mem_write};
      for (int i = 1; i < int'(NSTG); i++) mem_d[i] = mem_q[i-1];
      flags_d = flags_q;
      if (ex_q.valid && ex_q.set_flags)
         flags_d = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q    <= '0;
         flags_q <= '0;
         for (int i = 0; i < int'(NSTG); i++) mem_q[i] <= '0;
      end else begin
         ex_q    <= ex_d;
         flags_q <= flags_d;
         for (int i = 0; i < int'(NSTG); i++) mem_q[i] <= mem_d[i];
      end
   end

   assign bus.reg2loc       = bus.instr_valid & rtype;
   assign bus.uncond_br     = uncond_c;
   assign bus.br_taken      = br_c;
   assign bus.flush         = br_c;
   assign bus.stall_req     = stall_req_c;
   assign bus.illegal       = bus.instr_valid & ~legal;
   assign bus.ex_alu_src    = ex_q.valid & ex_q.alu_src;
   assign bus.ex_alu_op     = ALUOP_W'(ex_q.alu_op);
   assign bus.mem_write     = mem_q[0].valid & mem_q[0].mem_write;
   assign bus.wb_reg_write  = mem_q[MEM_STAGES].valid & mem_q[MEM_STAGES].reg_write;
   assign bus.wb_mem_to_reg = mem_q[MEM_STAGES].valid & mem_q[MEM_STAGES].mem_to_reg;
   assign bus.flags         = flags_q;
endmodule
